// File: rtl/mc_cpu_pkg.sv
// mc_cpu_pkg: opcodes, FSM states, ALU ops and instruction field positions for mc_cpu
package mc_cpu_pkg;
    localparam int OP_HI = 31;
    localparam int OP_LO = 24;
    localparam int RD_HI = 23;
    localparam int RD_LO = 16;
    localparam int RS1_HI = 15;
    localparam int RS1_LO = 8;
    localparam int RS2_HI = 7;
    localparam int RS2_LO = 0;
    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV = 8'h01;
    localparam logic [7:0] OP_ADD = 8'h02;
    localparam logic [7:0] OP_SUB = 8'h03;
    localparam logic [7:0] OP_AND = 8'h04;
    localparam logic [7:0] OP_OR = 8'h05;
    localparam logic [7:0] OP_JUMP = 8'h06;
    localparam logic [7:0] OP_BEQ = 8'h07;
    localparam logic [7:0] OP_LWD = 8'h08;
    localparam logic [7:0] OP_LWI = 8'h09;
    localparam logic [7:0] OP_SWD = 8'h0A;
    localparam logic [7:0] OP_SWI = 8'h0B;
    localparam logic [7:0] OP_BNE = 8'h0C;
    localparam logic [7:0] OP_SLL = 8'h0D;
    localparam logic [7:0] OP_SRL = 8'h0E;
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
    typedef enum logic [2:0] {ALU_B, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLL, ALU_SRL} alu_op_t;
    function automatic alu_op_t alu_op_of(input logic [7:0] op);
        case (op)
            OP_ADD: return ALU_ADD;
            OP_SUB, OP_BEQ, OP_BNE: return ALU_SUB;
            OP_AND: return ALU_AND;
            OP_OR: return ALU_OR;
            OP_SLL: return ALU_SLL;
            OP_SRL: return ALU_SRL;
            OP_LOADI, OP_MOV: return ALU_B;
            default: return ALU_B;
        endcase
    endfunction
    function automatic logic uses_imm(input logic [7:0] op);
        return op inside {OP_LOADI, OP_LWI, OP_SWI, OP_SLL, OP_SRL};
    endfunction
endpackage

// File: rtl/mc_cpu_if.sv
// mc_cpu_if: instruction and data memory request/busywait bus of mc_cpu
interface mc_cpu_if #(parameter int DATA_W = 8) ();
    logic [31:0] instruction;
    logic [31:0] pc;
    logic i_busywait;
    logic i_read;
    logic read;
    logic write;
    logic busywait;
    logic halted;
    logic [DATA_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    modport master (
        input instruction, i_busywait, readdata, busywait,
        output pc, i_read, read, write, address, writedata, halted
    );
    modport slave (
        output instruction, i_busywait, readdata, busywait,
        input pc, i_read, read, write, address, writedata, halted
    );
endinterface

// File: rtl/mc_regfile.sv
// mc_regfile: 2-read/1-write register file with synchronous active-low clear
module mc_regfile #(
    parameter int DATA_W = 8,
    parameter int NREGS = 8
) (
    input logic clk,
    input logic rst_n,
    input logic we,
    input logic [$clog2(NREGS)-1:0] waddr,
    input logic [DATA_W-1:0] wdata,
    input logic [$clog2(NREGS)-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input logic [$clog2(NREGS)-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);
    logic [DATA_W-1:0] regs [NREGS];
    always_ff @(posedge clk) begin
        if (!rst_n)
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        else if (we)
            regs[waddr] <= wdata;
    end
    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];
endmodule

// File: rtl/mc_cpu.sv
// mc_cpu: multi-cycle core (fetch/decode/exec/mem/wb) with stalling instruction and data memory
module mc_cpu
    import mc_cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREGS = 8
) (
    input logic clk,
    input logic rst_n,
    mc_cpu_if.master bus
);
    localparam int IW = $clog2(NREGS);
    state_t state, state_next;
    alu_op_t alu_op;
    logic [31:0] pc, ir, target;
    logic [DATA_W-1:0] a, b, res, alu_y, rd1, rd2, imm;
    logic [7:0] op, shamt;
    logic is_load, is_store, is_branch, zero, take;
    logic unused;
    assign op = ir[OP_HI:OP_LO];
    assign shamt = ir[RS2_HI:RS2_LO];
    assign imm = DATA_W'($signed(shamt));
    assign unused = ^ir[RS1_HI:RS1_LO];
    assign is_load = op == OP_LWD || op == OP_LWI;
    assign is_store = op == OP_SWD || op == OP_SWI;
    assign is_branch = op == OP_JUMP || op == OP_BEQ || op == OP_BNE;
    assign target = pc + 32'd4 + {{22{ir[RD_HI]}}, ir[RD_HI:RD_LO], 2'b00};
    assign alu_op = alu_op_of(op);
    assign alu_y = alu_op == ALU_ADD ? a + b
                 : alu_op == ALU_SUB ? a - b
                 : alu_op == ALU_AND ? a & b
                 : alu_op == ALU_OR  ? a | b
                 : alu_op == ALU_SLL ? (shamt >= 8'(DATA_W) ? '0 : a << shamt)
                 : alu_op == ALU_SRL ? (shamt >= 8'(DATA_W) ? '0 : a >> shamt)
                 : b;
    // branches run the ALU as a subtract, so equality is a zero result
    assign zero = alu_y == '0;
    assign take = op == OP_JUMP || (op == OP_BEQ && zero) || (op == OP_BNE && !zero);
    mc_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
        .clk(clk),
        .rst_n(rst_n),
        .we(state == S_WB),
        .waddr(ir[RD_LO +: IW]),
        .wdata(res),
        .raddr1(ir[RS1_LO +: IW]),
        .rdata1(rd1),
        .raddr2(ir[RS2_LO +: IW]),
        .rdata2(rd2)
    );
    always_ff @(posedge clk) state <= !rst_n ? S_FETCH : state_next;
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: state_next = bus.i_busywait ? S_FETCH : S_DECODE;
            S_DECODE: state_next = op > OP_SRL ? S_TRAP : S_EXEC;
            S_EXEC: state_next = is_branch ? S_FETCH : (is_load || is_store) ? S_MEM : S_WB;
            S_MEM: state_next = bus.busywait ? S_MEM : is_load ? S_WB : S_FETCH;
            S_WB: state_next = S_FETCH;
            default: state_next = S_TRAP;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= '0;
            ir <= '0;
            a <= '0;
            b <= '0;
            res <= '0;
        end else begin
            case (state)
                S_FETCH: if (!bus.i_busywait) ir <= bus.instruction;
                S_DECODE: begin
                    a <= rd1;
                    b <= uses_imm(op) ? imm : rd2;
                end
                S_EXEC: begin
                    res <= alu_y;
                    if (is_branch) pc <= take ? target : pc + 32'd4;
                end
                S_MEM: if (!bus.busywait) begin
                    if (is_load) res <= bus.readdata;
                    else pc <= pc + 32'd4;
                end
                S_WB: pc <= pc + 32'd4;
                default: pc <= pc;
            endcase
        end
    end
    assign bus.pc = pc;
    assign bus.i_read = state == S_FETCH;
    assign bus.read = state == S_MEM && is_load;
    assign bus.write = state == S_MEM && is_store;
    assign bus.address = res;
    assign bus.writedata = a;
    assign bus.halted = state == S_TRAP;
endmodule

// File: tb/tb_mc_cpu.sv
// tb_mc_cpu: directed program for mc_cpu (DATA_W=16) with a store scoreboard and cycle checks
module tb_mc_cpu;
    import mc_cpu_pkg::*;
    localparam int DW = 16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    mc_cpu_if #(.DATA_W(DW)) bus ();
    mc_cpu #(.DATA_W(DW), .NREGS(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    typedef struct {
        logic [DW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;
    wr_t exp_q [$];
    wr_t mon_e;
    logic [31:0] imem [64];
    logic [DW-1:0] dmem [256];
    int n_wait = 0;
    int bw_cnt = 0;
    int rd_hi = 0;
    int tests = 0;
    int fails = 0;
    assign bus.instruction = imem[bus.pc[7:2]];
    assign bus.i_busywait = 1'b0;
    assign bus.readdata = dmem[bus.address[7:0]];
    assign bus.busywait = (bus.read || bus.write) && bw_cnt < n_wait;
    function automatic logic [31:0] ins(input logic [7:0] o, input int d, input int s1, input int s2);
        return {o, 8'(d), 8'(s1), 8'(s2)};
    endfunction
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic push(input logic [DW-1:0] addr, input logic [DW-1:0] data);
        exp_q.push_back('{addr, data});
    endtask
    task automatic step(input string tag, input int exp_cyc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.i_read && n < 40);
        check(tag, n, exp_cyc);
    endtask
    // data memory: busywait held for n_wait cycles of each request, write on the accepting edge
    always @(posedge clk) begin
        bw_cnt <= ((bus.read || bus.write) && bus.busywait) ? bw_cnt + 1 : 0;
        if (bus.write && !bus.busywait) dmem[bus.address[7:0]] = bus.writedata;
    end
    always @(negedge clk) begin
        if (bus.read) rd_hi++;
        if (bus.write && !bus.busywait) begin
            if (exp_q.size() == 0) check("sb_nonempty", 32'(exp_q.size() != 0), 1);
            else begin
                mon_e = exp_q.pop_front();
                check("st_addr", 32'(bus.address), 32'(mon_e.addr));
                check("st_data", 32'(bus.writedata), 32'(mon_e.data));
            end
        end
    end
    initial begin
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
        for (int i = 0; i < 256; i++) dmem[i] = '0;
        dmem[8'h20] = 16'h00A5;
        imem[0] = ins(OP_LOADI, 1, 0, 5);
        imem[1] = ins(OP_LOADI, 2, 0, 3);
        imem[2] = ins(OP_ADD, 3, 1, 2);
        imem[3] = ins(OP_SUB, 4, 1, 2);
        imem[4] = ins(OP_LOADI, 5, 0, 'h40);
        imem[5] = ins(OP_SWD, 0, 3, 5);
        imem[6] = ins(OP_SWI, 0, 4, 'h41);
        imem[7] = ins(OP_LOADI, 1, 0, 7);
        imem[8] = ins(OP_LOADI, 2, 0, 7);
        imem[9] = ins(OP_BNE, 2, 1, 2);
        imem[10] = ins(OP_BEQ, -1, 1, 2);
        imem[12] = ins(OP_LWI, 5, 0, 'h20);
        imem[13] = ins(OP_SWI, 0, 5, 'h42);
        imem[14] = ins(OP_LOADI, 1, 0, 1);
        imem[15] = ins(OP_LOADI, 6, 0, 'h80);
        imem[16] = ins(OP_SLL, 6, 6, 8);
        imem[17] = ins(OP_OR, 1, 1, 6);
        imem[18] = ins(OP_SLL, 2, 1, 1);
        imem[19] = ins(OP_SRL, 3, 1, 20);
        imem[20] = ins(OP_SRL, 7, 1, 15);
        imem[21] = ins(OP_SLL, 6, 1, 16);
        imem[22] = ins(OP_LOADI, 4, 0, 'h10);
        imem[23] = ins(OP_SWD, 0, 1, 4);
        imem[24] = ins(OP_SWI, 0, 2, 'h11);
        imem[25] = ins(OP_SWI, 0, 3, 'h12);
        imem[26] = ins(OP_SWI, 0, 7, 'h13);
        imem[27] = ins(OP_SWI, 0, 6, 'h14);
        imem[28] = ins(OP_SUB, 0, 7, 2);
        imem[29] = ins(OP_SWI, 0, 0, 'h15);
        imem[30] = ins(OP_MOV, 5, 1, 2);
        imem[31] = ins(OP_LWD, 3, 0, 4);
        imem[32] = ins(OP_SWI, 0, 5, 'h16);
        imem[33] = ins(OP_SWI, 0, 3, 'h17);
        imem[34] = ins(OP_AND, 0, 1, 7);
        imem[35] = ins(OP_SWI, 0, 0, 'h18);
        imem[36] = ins(OP_LWI, 5, 0, 'h20);
        repeat (2) @(negedge clk);
        check("rst_pc", bus.pc, 0);
        check("rst_read", 32'(bus.read), 0);
        check("rst_write", 32'(bus.write), 0);
        check("rst_halted", 32'(bus.halted), 0);
        rst_n = 1'b1;
        check("rel_iread", 32'(bus.i_read), 1);
        step("loadi_cyc", 4);
        step("loadi2_cyc", 4);
        step("add_cyc", 4);
        step("sub_cyc", 4);
        check("pc_16", bus.pc, 16);
        step("loadi_base_cyc", 4);
        push(16'h40, 16'd8);
        step("swd_cyc", 4);
        push(16'h41, 16'd2);
        step("swi_cyc", 4);
        step("loadi_r1_cyc", 4);
        step("loadi_r2_cyc", 4);
        step("bne_cyc", 3);
        check("bne_pc", bus.pc, 40);
        step("beq_cyc", 3);
        check("beq_pc", bus.pc, 40);
        imem[10] = ins(OP_JUMP, 1, 0, 0);
        step("jump_cyc", 3);
        check("jump_pc", bus.pc, 48);
        n_wait = 3;
        rd_hi = 0;
        step("lwi_stall_cyc", 8);
        check("read_hi_cycles", rd_hi, 4);
        n_wait = 0;
        push(16'h42, 16'h00A5);
        step("swi_a5_cyc", 4);
        for (int i = 14; i <= 22; i++) step($sformatf("alu_cyc_%0d", i), 4);
        push(16'h10, 16'h8001);
        push(16'h11, 16'h0002);
        push(16'h12, 16'h0000);
        push(16'h13, 16'h0001);
        push(16'h14, 16'h0000);
        for (int i = 23; i <= 27; i++) step($sformatf("st_cyc_%0d", i), 4);
        step("sub_wrap_cyc", 4);
        push(16'h15, 16'hFFFF);
        step("swi_wrap_cyc", 4);
        step("mov_cyc", 4);
        step("lwd_cyc", 5);
        push(16'h16, 16'h0002);
        push(16'h17, 16'h8001);
        step("swi_mov_cyc", 4);
        step("swi_lwd_cyc", 4);
        step("and_cyc", 4);
        push(16'h18, 16'h0001);
        step("swi_and_cyc", 4);
        check("pc_144", bus.pc, 144);
        n_wait = 20;
        repeat (3) @(negedge clk);
        check("mem_read_hi", 32'(bus.read), 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midmem_read", 32'(bus.read), 0);
        check("midmem_write", 32'(bus.write), 0);
        check("midmem_pc", bus.pc, 0);
        n_wait = 0;
        imem[0] = ins(OP_SWI, 0, 5, 'h19);
        imem[1] = 32'h3F00_0000;
        push(16'h19, 16'h0000);
        rst_n = 1'b1;
        step("post_rst_swi_cyc", 4);
        @(negedge clk);
        check("decode_halted", 32'(bus.halted), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("trap_halted_%0d", i), 32'(bus.halted), 1);
            check($sformatf("trap_iread_%0d", i), 32'(bus.i_read), 0);
            check($sformatf("trap_pc_%0d", i), bus.pc, 4);
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("unhalt_on_reset", 32'(bus.halted), 0);
        rst_n = 1'b1;
        check("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
